// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready request and
// response channels, with byte-lane writes and a fixed number of wait states.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down wait states before the access
// RESP   | response presented, held until rsp_ready_i
`timescale 1ns/1ps
module dmem_resp #(
   parameter int unsigned DW             = 32,
   parameter int unsigned MEM_SIZE_IN_KB = 1,
   parameter int unsigned NO_OF_WORDS    = MEM_SIZE_IN_KB*1024/4,
   parameter int unsigned WAIT_STATES    = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_we_i,
   input  logic [DW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   input  logic [3:0]    req_be_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o
);

   localparam int unsigned AW       = (NO_OF_WORDS > 1) ? $clog2(NO_OF_WORDS) : 1;
   localparam logic [DW-3:0] NWORDS = (DW-2)'(NO_OF_WORDS);
   localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q;
   logic [DW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [3:0]    be_q;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [DW-1:0] mem [NO_OF_WORDS];

   logic          accept;
   logic          access;
   logic          acc_we;
   logic [DW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;
   logic [3:0]    acc_be;
   logic [DW-3:0] acc_idx;
   logic [AW-1:0] mem_idx;
   logic          acc_err;
   logic          mem_wr;
   logic [DW-1:0] mem_rd;

   assign req_ready_o = (state_q == S_IDLE) & rst_i;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign accept      = req_valid_i & req_ready_o;

   // With zero wait states the access happens on the accept edge, so it must
   // use the live request rather than the captured copy.
   always_comb begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      if (state_q == S_IDLE) begin
         acc_we    = req_we_i;
         acc_addr  = req_addr_i;
         acc_wdata = req_wdata_i;
         acc_be    = req_be_i;
      end
   end

   assign acc_idx = acc_addr[DW-1:2];
   assign mem_idx = acc_idx[AW-1:0];
   assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_idx >= NWORDS);
   assign access  = (WAIT_STATES == 0) ? accept
                                       : ((state_q == S_WAIT) & (cnt_q == 4'd0));
   assign mem_wr  = access & acc_we & ~acc_err;
   assign mem_rd  = mem[mem_idx];

   always_ff @(posedge clk_i) begin
      if (mem_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (acc_be[k]) begin
               mem[mem_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (access) begin
         err_d   = acc_err;
         rdata_d = (acc_err | acc_we) ? '0 : mem_rd;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: transaction-level model with per-cycle output compare,
// directed literal cases, randomized traffic and a zero-wait-state instance.
`timescale 1ns/1ps
module tb_dmem_resp;

   localparam int WS = 2;
   localparam int NW = 256;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        v0, ready0, we0, valid0, rr0, err0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  be0;

   dmem_resp #(.WAIT_STATES(WS)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   dmem_resp #(.WAIT_STATES(0)) dut0 (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(v0), .req_ready_o(ready0), .req_we_i(we0),
      .req_addr_i(addr0), .req_wdata_i(wdata0), .req_be_i(be0),
      .rsp_valid_o(valid0), .rsp_ready_i(rr0),
      .rsp_rdata_o(rdata0), .rsp_err_o(err0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level reference: response fixed at accept, store committed
   // at the access edge (accept + WS), response visible from then on.
   int          cyc = 0;
   bit          m_busy = 0;
   int          m_acc_edge = 0;
   bit          m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic [31:0] mem_m [NW];

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_busy = 0;
         end else begin
            if (m_busy && cyc > m_acc_edge && rsp_ready) begin
               m_busy = 0;
            end else if (!m_busy && req_valid) begin
               m_busy     = 1;
               m_acc_edge = cyc + WS;
               m_we       = req_we;
               m_addr     = req_addr;
               m_wdata    = req_wdata;
               m_be       = req_be;
               m_err      = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= NW);
               m_rdata    = (m_err || m_we) ? 32'h0 : mem_m[req_addr[9:2]];
            end
            if (m_busy && cyc == m_acc_edge && m_we && !m_err) begin
               for (int k = 0; k < 4; k++)
                  if (m_be[k]) mem_m[m_addr[9:2]][8*k +: 8] = m_wdata[8*k +: 8];
            end
         end
      end
   end

   initial begin
      forever begin
         logic        exp_r, exp_v, exp_e;
         logic [31:0] exp_d;
         @(negedge clk);
         if (!rst_n) begin
            exp_r = 0;
            exp_v = 0;
         end else begin
            exp_r = !m_busy;
            exp_v = m_busy && (cyc >= m_acc_edge);
         end
         exp_d = exp_v ? m_rdata : 32'h0;
         exp_e = exp_v ? m_err : 1'b0;
         check("req_ready", {31'b0, req_ready}, {31'b0, exp_r});
         check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
         check("rsp_rdata", rsp_rdata, exp_d);
         check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns after the response has been consumed.
   task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rdata, output bit err,
                         output int lat, output int t0);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("ready_timeout", 0, 1);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      @(posedge clk);
      t0 = cyc;
      #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = (hold == 0);
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("rsp_timeout", 0, 1);
      lat   = cyc + 1 - t0;
      rdata = rsp_rdata;
      err   = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", {31'b0, rsp_valid}, 1);
         check("hold_rdata", rsp_rdata, rdata);
         check("hold_err", {31'b0, rsp_err}, {31'b0, err});
         check("hold_req_ready", {31'b0, req_ready}, 0);
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      req_valid = 0;
      check("idle_after_consume", {31'b0, req_ready}, 1);
   endtask

   logic [31:0] r_d;
   bit          r_e;
   int          r_lat, r_t0, prev_t0;
   bit          prev_h0;

   task automatic txn(input string name, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic [31:0] exp_d, input bit exp_e);
      do_txn(we, addr, wdata, be, hold, r_d, r_e, r_lat, r_t0);
      check({name, "_rdata"}, r_d, exp_d);
      check({name, "_err"}, {31'b0, r_e}, {31'b0, exp_e});
      check({name, "_latency"}, r_lat, WS + 1);
   endtask

   initial begin
      int kind, w, hold;
      logic [31:0] a;
      rst_n = 0; req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h0;
      req_be = 4'hF; rsp_ready = 0;
      v0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0; rr0 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", {31'b0, req_ready}, 0);
      check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
      check("reset_rdata", rsp_rdata, 0);
      check("reset_err", {31'b0, rsp_err}, 0);
      rst_n = 1; req_valid = 0;
      @(posedge clk); #1;

      txn("store10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
      txn("load10", 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
      txn("store20", 1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 0);
      txn("store20_be5", 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0, 0);
      txn("load20", 0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 0);
      txn("store0", 1, 32'h0, 32'h55AA00FF, 4'hF, 0, 32'h0, 0);
      txn("load3_err", 0, 32'h3, 32'h0, 4'h0, 0, 32'h0, 1);
      txn("store400_err", 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1);
      txn("load0", 0, 32'h0, 32'h0, 4'h0, 0, 32'h55AA00FF, 0);
      txn("store_be0", 1, 32'h0, 32'h01020304, 4'h0, 0, 32'h0, 0);
      txn("load0_be0", 0, 32'h0, 32'h0, 4'h0, 0, 32'h55AA00FF, 0);
      txn("backpressure", 0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 0);

      // Reset during WAIT abandons the pending store.
      txn("store40", 1, 32'h40, 32'h12345678, 4'hF, 0, 32'h0, 0);
      req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check("midrst_valid", {31'b0, rsp_valid}, 0);
      check("midrst_ready", {31'b0, req_ready}, 0);
      check("midrst_rdata", rsp_rdata, 0);
      check("midrst_err", {31'b0, rsp_err}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("no_rsp_after_reset", {31'b0, rsp_valid}, 0);
      end
      txn("load40", 0, 32'h40, 32'h0, 4'h0, 0, 32'h12345678, 0);

      for (int i = 64; i < 96; i++)
         txn("init", 1, 32'(i * 4), $urandom, 4'hF, 0, 32'h0, 0);
      txn("init_top", 1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, 0, 32'h0, 0);
      txn("load_top", 0, 32'h3FC, 32'h0, 4'h0, 0, 32'hA5A5_5A5A, 0);

      prev_h0 = 0;
      prev_t0 = 0;
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         w    = $urandom_range(64, 95);
         hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         case (kind)
            0, 1, 2, 3: a = 32'(w * 4);
            4, 5, 6:    a = 32'(w * 4);
            7:          a = 32'(w * 4) | 32'($urandom_range(1, 3));
            8:          a = 32'h400 + 32'($urandom_range(0, 4095) * 4);
            default:    a = 32'h3FC;
         endcase
         do_txn((kind >= 4 && kind <= 6) || (kind >= 7 && $urandom_range(0, 1) == 1),
                a, $urandom, 4'($urandom), hold, r_d, r_e, r_lat, r_t0);
         check("rand_latency", r_lat, WS + 1);
         if (prev_h0) check("throughput", r_t0 - prev_t0, WS + 2);
         prev_t0 = r_t0;
         prev_h0 = (hold == 0);
      end

      // Zero-wait-state instance: store, then back-to-back loads.
      rr0 = 1;
      check("ws0_ready_idle", {31'b0, ready0}, 1);
      v0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'h0BADC0DE; be0 = 4'hF;
      @(posedge clk); #1;
      check("ws0_store_valid", {31'b0, valid0}, 1);
      check("ws0_store_rdata", rdata0, 0);
      check("ws0_store_err", {31'b0, err0}, 0);
      we0 = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         check("ws0_valid", {31'b0, valid0}, (k % 2 == 0) ? 1 : 0);
         check("ws0_ready", {31'b0, ready0}, (k % 2 == 0) ? 0 : 1);
         check("ws0_rdata", rdata0, (k % 2 == 0) ? 32'h0BADC0DE : 32'h0);
         check("ws0_err", {31'b0, err0}, 0);
      end
      v0 = 0;
      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
